cart_mbc1: RTL and testbench

- Cycle-level model of an MBC1 cartridge: the responder end of the external cartridge bus driven by ext_cpu_busses.
- Samples the console's A/D/RD/WR/CS pins on clk1 and decodes MBC1 register writes.
- Maps console addresses onto an external ROM/SRAM array model and returns read data onto the data pins.
- Used at the dmg top in place of the stubbed d_in cartridge data.

---
 rtl/cart_mbc1.sv | 195 +++++++++++++++++++
 tb/tb_cart_mbc1.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mbc1.sv
// ----------------------------------------------------------------------------
// cart_mbc1 - cycle-level MBC1 cartridge, responder side of the external
// cartridge bus.
//
// The console pins are registered on clk1 and every decode works from the
// registered copies. A write is latched while WR is low and committed once on
// the WR rising edge. Reads are answered one cycle after sampling, so the
// pin-to-pin latency is two clk1 edges.
//
// Ports
//   clk1, nreset       clock, asynchronous active-low reset
//   a, d_in            console address / data pins
//   nrd, nwr, ncs      console RD / WR / CS strobes (active low)
//   d_out, d_oe        read data returned to the console and its enable
//   rom_a, rom_d       ROM array address / combinational read data
//   ram_a, ram_d       SRAM array address / combinational read data
//   ram_wd, ram_we     SRAM write data / one-cycle write strobe
// ----------------------------------------------------------------------------
module cart_mbc1 #(
    parameter int ROM_AW      = 21,
    parameter int RAM_PRESENT = 1
) (
    input  logic              clk1,
    input  logic              nreset,
    input  logic [15:0]       a,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              nrd,
    input  logic              nwr,
    input  logic              ncs,
    output logic [ROM_AW-1:0] rom_a,
    input  logic [7:0]        rom_d,
    output logic [14:0]       ram_a,
    input  logic [7:0]        ram_d,
    output logic [7:0]        ram_wd,
    output logic              ram_we
);

    localparam logic HAS_RAM = (RAM_PRESENT != 0);

    // Registered pin copies
    logic [15:0] a_q;
    logic [7:0]  d_q;
    logic        nrd_q, nwr_q, ncs_q;

    // Write latch
    logic [15:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic        wcs_q, wcs_d;
    logic        wpend_q, wpend_d;

    // MBC1 registers
    logic        ram_en_q, ram_en_d;
    logic [4:0]  bank1_q, bank1_d;
    logic [1:0]  bank2_q, bank2_d;
    logic        mode_q, mode_d;

    // Read path
    logic        d_oe_q, d_oe_d;
    logic [7:0]  d_out_q, d_out_d;

    logic        commit;
    logic        ram_wr_hit;
    logic        ram_rd_hit;
    logic [1:0]  bank_hi;
    logic [4:0]  bank1_eff;
    logic [20:0] rom_full;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            a_q   <= '0;
            d_q   <= '0;
            nrd_q <= 1'b1;
            nwr_q <= 1'b1;
            ncs_q <= 1'b1;
        end else begin
            a_q   <= a;
            d_q   <= d_in;
            nrd_q <= nrd;
            nwr_q <= nwr;
            ncs_q <= ncs;
        end
    end

    // First sampled WR-high cycle after a low pulse commits the latched write.
    assign commit     = wpend_q & nwr_q;
    assign ram_wr_hit = commit & (wa_q[15:13] == 3'b101) & wcs_q & ram_en_q & HAS_RAM;
    assign ram_rd_hit = (a_q[15:13] == 3'b101) & ~ncs_q & ram_en_q & HAS_RAM;

    // ------------------------------------------------------------------
    // Write latch and register commit
    // ------------------------------------------------------------------
    always_comb begin
        wa_d     = wa_q;
        wd_d     = wd_q;
        wcs_d    = wcs_q;
        wpend_d  = wpend_q;
        ram_en_d = ram_en_q;
        bank1_d  = bank1_q;
        bank2_d  = bank2_q;
        mode_d   = mode_q;

        if (!nwr_q) begin
            // Keep re-capturing while WR is low; the last sample wins.
            wa_d    = a_q;
            wd_d    = d_q;
            wcs_d   = ~ncs_q;
            wpend_d = 1'b1;
        end else if (commit) begin
            wpend_d = 1'b0;
            unique case (wa_q[15:13])
                3'b000:  ram_en_d = (wd_q[3:0] == 4'hA);
                3'b001:  bank1_d  = wd_q[4:0];
                3'b010:  bank2_d  = wd_q[1:0];
                3'b011:  mode_d   = wd_q[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            wa_q     <= '0;
            wd_q     <= '0;
            wcs_q    <= 1'b0;
            wpend_q  <= 1'b0;
            ram_en_q <= 1'b0;
            bank1_q  <= '0;
            bank2_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            wcs_q    <= wcs_d;
            wpend_q  <= wpend_d;
            ram_en_q <= ram_en_d;
            bank1_q  <= bank1_d;
            bank2_q  <= bank2_d;
            mode_q   <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Address mapping
    // ------------------------------------------------------------------
    assign bank_hi   = mode_q ? bank2_q : 2'b00;
    // Only the 5 bank1 bits are tested for zero, so 0x20/0x40/0x60 -> +1.
    assign bank1_eff = (bank1_q == 5'd0) ? 5'd1 : bank1_q;
    assign rom_full  = a_q[14] ? {bank2_q, bank1_eff, a_q[13:0]}
                               : {bank_hi, 5'd0, a_q[13:0]};

    generate
        if (ROM_AW <= 21) begin : g_rom_trunc
            assign rom_a = rom_full[ROM_AW-1:0];
        end else begin : g_rom_ext
            assign rom_a = {{(ROM_AW-21){1'b0}}, rom_full};
        end
    endgenerate

    // The SRAM address follows the latched write address only in the
    // strobe cycle; otherwise it tracks the live bus address for reads.
    assign ram_a  = {bank_hi, ram_wr_hit ? wa_q[12:0] : a_q[12:0]};
    assign ram_we = ram_wr_hit;
    assign ram_wd = wd_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        d_oe_d  = nwr_q & ~nrd_q & (~a_q[15] | ram_rd_hit);
        d_out_d = 8'hFF;
        if (!a_q[15])
            d_out_d = rom_d;
        else if (ram_rd_hit)
            d_out_d = ram_d;
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            d_oe_q  <= 1'b0;
            d_out_q <= 8'hFF;
        end else begin
            d_oe_q  <= d_oe_d;
            d_out_q <= d_out_d;
        end
    end

    assign d_oe  = d_oe_q;
    assign d_out = d_out_q;

endmodule

// File: tb/tb_cart_mbc1.sv
// ----------------------------------------------------------------------------
// tb_cart_mbc1 - self-checking bench for cart_mbc1.
// Directed vector table, hand-written multi-cycle sequences, then random
// traffic checked against a behavioural MBC1 model.
// ----------------------------------------------------------------------------
module tb_cart_mbc1;

    logic        clk1 = 1'b0;
    logic        nreset;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        nrd, nwr, ncs;
    logic [20:0] rom_a;
    logic [7:0]  rom_d;
    logic [14:0] ram_a;
    logic [7:0]  ram_d;
    logic [7:0]  ram_wd;
    logic        ram_we;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    cart_mbc1 #(.ROM_AW(21), .RAM_PRESENT(1)) dut (
        .clk1(clk1), .nreset(nreset), .a(a), .d_in(d_in),
        .d_out(d_out), .d_oe(d_oe), .nrd(nrd), .nwr(nwr), .ncs(ncs),
        .rom_a(rom_a), .rom_d(rom_d), .ram_a(ram_a), .ram_d(ram_d),
        .ram_wd(ram_wd), .ram_we(ram_we)
    );

    // ---------------- external arrays (environment) ----------------
    function automatic logic [7:0] romf(input logic [20:0] x);
        return x[7:0] ^ x[15:8] ^ {3'b000, x[20:16]} ^ 8'h5A;
    endfunction

    logic [7:0] ram_mem [0:32767];
    assign rom_d = romf(rom_a);
    assign ram_d = ram_mem[ram_a];
    always @(posedge clk1) if (ram_we) ram_mem[ram_a] <= ram_wd;

    // Strobe monitor: counts cycles with ram_we high.
    int         we_cnt;
    logic [14:0] we_a;
    logic [7:0]  we_wd;
    always @(negedge clk1) begin
        if (ram_we) begin
            we_cnt = we_cnt + 1;
            we_a   = ram_a;
            we_wd  = ram_wd;
        end
    end

    // ---------------- behavioural model ----------------
    bit       m_ram_en;
    int       m_bank1, m_bank2, m_mode;
    bit [7:0] m_mem [0:32767];

    function automatic void model_reset();
        m_ram_en = 0; m_bank1 = 0; m_bank2 = 0; m_mode = 0;
    endfunction

    function automatic int model_rom_addr(input int addr);
        int eff;
        if ((addr / 16384) % 2 == 0)
            return (m_mode != 0 ? m_bank2 : 0) * 524288 + addr % 16384;
        eff = (m_bank1 == 0) ? 1 : m_bank1;
        return m_bank2 * 524288 + eff * 16384 + addr % 16384;
    endfunction

    function automatic int model_ram_addr(input int addr);
        return (m_mode != 0 ? m_bank2 : 0) * 8192 + addr % 8192;
    endfunction

    function automatic bit in_sram(input int addr);
        return addr >= 'hA000 && addr < 'hC000;
    endfunction

    // Returns 1 when the write should produce an SRAM strobe.
    function automatic bit model_write(input int addr, input int data, input bit ncs_v);
        if (addr < 'h2000)      m_ram_en = (data % 16 == 10);
        else if (addr < 'h4000) m_bank1 = data % 32;
        else if (addr < 'h6000) m_bank2 = data % 4;
        else if (addr < 'h8000) m_mode = data % 2;
        else if (in_sram(addr) && !ncs_v && m_ram_en) begin
            m_mem[model_ram_addr(addr)] = data[7:0];
            return 1;
        end
        return 0;
    endfunction

    function automatic bit model_oe(input int addr, input bit ncs_v);
        return addr < 'h8000 || (in_sram(addr) && !ncs_v && m_ram_en);
    endfunction

    function automatic logic [7:0] model_data(input int addr);
        if (addr < 'h8000) return romf(21'(model_rom_addr(addr)));
        return m_mem[model_ram_addr(addr)];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic ncs_v, input int len, input bit exp_we);
        logic [14:0] exp_ra;
        bit          dummy;
        exp_ra = 15'(model_ram_addr(int'(addr)));
        @(negedge clk1);
        we_cnt = 0;
        a = addr; d_in = data; ncs = ncs_v; nwr = 1'b0;
        repeat (len) @(posedge clk1);
        @(negedge clk1);
        nwr = 1'b1; ncs = 1'b1;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("we_count", we_cnt, {31'd0, exp_we});
        if (exp_we && we_cnt == 1) begin
            check("we_ram_a", {17'd0, we_a}, {17'd0, exp_ra});
            check("we_ram_wd", {24'd0, we_wd}, {24'd0, data});
        end
        dummy = model_write(int'(addr), int'(data), ncs_v);
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic ncs_v,
                            input bit chk_rom, input logic [20:0] exp_rom, input bit exp_oe);
        logic [7:0] exp_d;
        exp_d = model_data(int'(addr));
        @(negedge clk1);
        a = addr; ncs = ncs_v; nrd = 1'b0;
        @(posedge clk1);
        @(negedge clk1);
        if (chk_rom) check("rom_a", {11'd0, rom_a}, {11'd0, exp_rom});
        if (in_sram(int'(addr)))
            check("ram_a_rd", {17'd0, ram_a}, 32'(model_ram_addr(int'(addr))));
        check("oe_early", {31'd0, d_oe}, 32'd0);
        @(posedge clk1);
        @(negedge clk1);
        check("oe", {31'd0, d_oe}, {31'd0, exp_oe});
        if (exp_oe) check("d_out", {24'd0, d_out}, {24'd0, exp_d});
        nrd = 1'b1; ncs = 1'b1;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        check("oe_release", {31'd0, d_oe}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        nreset = 1'b0;
        nrd = 1'b1; nwr = 1'b1; ncs = 1'b1; a = '0; d_in = '0;
        repeat (2) @(negedge clk1);
        check("rst_oe", {31'd0, d_oe}, 32'd0);
        check("rst_dout", {24'd0, d_out}, 32'hFF);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_wd", {24'd0, ram_wd}, 32'd0);
        check("rst_rom_a", {11'd0, rom_a}, 32'd0);
        nreset = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        ncs;
        bit          chk_rom;
        logic [20:0] exp_rom;
        bit          exp_oe;
        bit          exp_we;
    } vec_t;

    function automatic vec_t vr(input logic [15:0] ad, input logic nc, input bit cr,
                                input logic [20:0] er, input bit eo);
        vec_t v;
        v.wr = 0; v.addr = ad; v.data = 8'h00; v.ncs = nc;
        v.chk_rom = cr; v.exp_rom = er; v.exp_oe = eo; v.exp_we = 0;
        return v;
    endfunction

    function automatic vec_t vw(input logic [15:0] ad, input logic [7:0] dt,
                                input logic nc, input bit ew);
        vec_t v;
        v.wr = 1; v.addr = ad; v.data = dt; v.ncs = nc;
        v.chk_rom = 0; v.exp_rom = '0; v.exp_oe = 0; v.exp_we = ew;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
        we_cnt = 0;
        nreset = 1'b0;
        nrd = 1'b1; nwr = 1'b1; ncs = 1'b1; a = '0; d_in = '0;

        vt.push_back(vr(16'h4123, 1'b1, 1, 21'h04123, 1));
        vt.push_back(vw(16'h2000, 8'h00, 1'b1, 0));
        vt.push_back(vr(16'h4000, 1'b1, 1, 21'h04000, 1));
        vt.push_back(vw(16'h2000, 8'h1F, 1'b1, 0));
        vt.push_back(vr(16'h4000, 1'b1, 1, 21'h7C000, 1));
        vt.push_back(vw(16'h2000, 8'h20, 1'b1, 0));
        vt.push_back(vr(16'h4000, 1'b1, 1, 21'h04000, 1));
        vt.push_back(vw(16'h4000, 8'h02, 1'b1, 0));
        vt.push_back(vw(16'h2000, 8'h05, 1'b1, 0));
        vt.push_back(vr(16'h5555, 1'b1, 1, 21'h115555, 1));
        vt.push_back(vr(16'h0100, 1'b1, 1, 21'h00100, 1));
        vt.push_back(vw(16'h6000, 8'h01, 1'b1, 0));
        vt.push_back(vr(16'h0100, 1'b1, 1, 21'h100100, 1));
        vt.push_back(vw(16'h6000, 8'h00, 1'b1, 0));
        vt.push_back(vr(16'hA010, 1'b0, 0, 21'h0, 0));
        vt.push_back(vw(16'h0000, 8'h0A, 1'b1, 0));
        vt.push_back(vw(16'hA010, 8'h5A, 1'b0, 1));
        vt.push_back(vr(16'hA010, 1'b0, 0, 21'h0, 1));
        vt.push_back(vw(16'h0000, 8'h00, 1'b1, 0));
        vt.push_back(vw(16'hA010, 8'h77, 1'b0, 0));
        vt.push_back(vr(16'hA010, 1'b0, 0, 21'h0, 0));

        do_reset();
        foreach (vt[i]) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].data, vt[i].ncs, 2, vt[i].exp_we);
            else          bus_read(vt[i].addr, vt[i].ncs, vt[i].chk_rom, vt[i].exp_rom, vt[i].exp_oe);
        end

        // Long WR pulses commit exactly once.
        do_reset();
        bus_write(16'h0000, 8'h0A, 1'b1, 2, 0);
        bus_write(16'hA020, 8'h33, 1'b0, 10, 1);
        bus_read(16'hA020, 1'b0, 0, 21'h0, 1);
        bus_write(16'h2000, 8'h03, 1'b1, 10, 0);
        bus_read(16'h4000, 1'b1, 1, 21'h0C000, 1);

        // Reset in the middle of a WR pulse discards the write.
        do_reset();
        @(negedge clk1);
        we_cnt = 0;
        a = 16'h2000; d_in = 8'h07; nwr = 1'b0;
        repeat (3) @(negedge clk1);
        nreset = 1'b0;
        @(negedge clk1);
        nreset = 1'b1;
        #1 nwr = 1'b1;
        model_reset();
        repeat (3) @(negedge clk1);
        check("rst_mid_we", we_cnt, 32'd0);
        bus_read(16'h4000, 1'b1, 1, 21'h04000, 1);

        // RD and WR together: write wins, no output drive.
        @(negedge clk1);
        a = 16'h1234; d_in = 8'h0A; nrd = 1'b0; nwr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk1);
            check("rdwr_oe", {31'd0, d_oe}, 32'd0);
        end
        nrd = 1'b1; nwr = 1'b1;
        repeat (3) @(negedge clk1);
        check("rdwr_oe_after", {31'd0, d_oe}, 32'd0);
        void'(model_write(32'h1234, 32'h0A, 1'b1));
        bus_write(16'hA7FF, 8'hC3, 1'b0, 2, 1);
        bus_read(16'hA7FF, 1'b0, 0, 21'h0, 1);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int unsigned sel;
            logic [15:0] ad;
            logic [7:0]  dt;
            logic        nc;
            sel = $urandom_range(0, 9);
            nc  = ($urandom_range(0, 3) == 0);
            dt  = 8'($urandom);
            case (sel)
                0: begin
                    ad = 16'($urandom_range(0, 'h1FFF));
                    if ($urandom_range(0, 1) == 1) dt = {dt[7:4], 4'hA};
                    bus_write(ad, dt, 1'b1, $urandom_range(1, 4), 0);
                end
                1: bus_write(16'($urandom_range('h2000, 'h3FFF)), dt, 1'b1, $urandom_range(1, 4), 0);
                2: bus_write(16'($urandom_range('h4000, 'h5FFF)), dt, 1'b1, $urandom_range(1, 4), 0);
                3: bus_write(16'($urandom_range('h6000, 'h7FFF)), dt, 1'b1, $urandom_range(1, 4), 0);
                4, 5: begin
                    ad = 16'($urandom_range('hA000, 'hBFFF));
                    bus_write(ad, dt, nc, $urandom_range(1, 4),
                              in_sram(int'(ad)) && !nc && m_ram_en);
                end
                6: begin
                    ad = 16'($urandom_range('hA000, 'hBFFF));
                    bus_read(ad, nc, 0, 21'h0, model_oe(int'(ad), nc));
                end
                default: begin
                    ad = 16'($urandom_range(0, 'h7FFF));
                    bus_read(ad, 1'b1, 1, 21'(model_rom_addr(int'(ad))), 1);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
